// File: rtl/priority_arbiter_8.sv
// Eight-way round-robin arbiter (descending search from the last grant) with a
// bounded hold time and a mandatory empty cycle between consecutive grants.
module priority_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    // Hold count value seen during the last cycle a grant may be kept.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] last_q, last_d;

    logic [7:0] low_mask;
    logic [7:0] masked_req;
    logic [2:0] winner;
    logic       released;
    logic       expired;

    function automatic logic [2:0] hi_enc(input logic [7:0] v);
        hi_enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) hi_enc = 3'(i);
        end
    endfunction

    // Bits below the last winner are searched first; if none is set the
    // unmasked pass wraps around to 7, 6, ... and finally the last winner.
    always_comb begin
        low_mask   = (8'd1 << last_q) - 8'd1;
        masked_req = req & low_mask;
        winner     = (masked_req != 8'd0) ? hi_enc(masked_req) : hi_enc(req);
    end

    assign released = ~req[idx_q];
    assign expired  = (hold_q >= HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= 8'd0;
            idx_q     <= 3'd0;
            timeout_q <= 1'b0;
            hold_q    <= 8'd0;
            last_q    <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case keeps this block free of
        // inferred latches on paths that do not change state.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req != 8'd0) state_d = S_BUSY;
            S_BUSY:  if (released || expired) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;
        case (state_q)
            S_IDLE: begin
                if (req != 8'd0) begin
                    grant_d = 8'd1 << winner;
                    idx_d   = winner;
                    last_d  = winner;
                    hold_d  = 8'd0;
                end
            end
            S_BUSY: begin
                hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
                if (released) begin
                    grant_d = 8'd0;
                    idx_d   = 3'd0;
                end else if (expired) begin
                    grant_d   = 8'd0;
                    idx_d     = 3'd0;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                grant_d = 8'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Directed and random checks of priority_arbiter_8 against a cycle model that
// tracks the current owner, how long it has held, and the post-release gap.
module tb_priority_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_owner;
    int m_held;
    int m_last;
    int m_cool;
    bit m_timeout;
    int wait_cnt [8];
    int max_wait;

    priority_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_held    = 0;
        m_last    = 0;
        m_cool    = 0;
        m_timeout = 1'b0;
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    endtask

    // One rising edge: owner keeps the grant while requesting and under the
    // hold limit; after a release one cycle passes before arbitration resumes.
    task automatic model_edge(input logic [7:0] r);
        int  idx;
        bit  found;
        m_timeout = 1'b0;
        for (int i = 0; i < 8; i++) if (!r[i]) wait_cnt[i] = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_cool  = 1;
            end else if (m_held == MAX_HOLD) begin
                m_owner   = -1;
                m_cool    = 1;
                m_timeout = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 8'd0) begin
            found = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                idx = (m_last - k + 8) % 8;
                if (!found && r[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
            m_last = m_owner;
            m_held = 1;
            for (int i = 0; i < 8; i++) begin
                if (i == m_owner) wait_cnt[i] = 0;
                else if (r[i]) wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_grant;
        logic [2:0] exp_idx;
        exp_grant = (m_owner >= 0) ? 8'(1 << m_owner) : 8'd0;
        exp_idx   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        check("grant", 32'(grant), 32'(exp_grant));
        check("grant_idx", 32'(grant_idx), 32'(exp_idx));
        check("grant_valid", 32'(grant_valid), 32'(exp_grant != 8'd0));
        check("timeout", 32'(timeout), 32'(m_timeout));
    endtask

    // Inputs change only at the falling edge; outputs are checked there too.
    task automatic step();
        logic [7:0] r;
        @(posedge clk);
        r = req;
        model_edge(r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int         got;
        bit         prev_valid;
        logic [2:0] seq [4];
        int         held_cycles;
        int         guard;

        max_wait = 0;
        model_reset();
        rst_n = 1'b1;
        req   = 8'd0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_idx", 32'(grant_idx), 32'd0);
        check("reset_valid", 32'(grant_valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);

        // Highest index wins on the first arbitration after reset.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'b1010_0101;
        step();
        check("first_grant", 32'(grant), 32'h80);
        check("first_idx", 32'(grant_idx), 32'd7);
        check("first_valid", 32'(grant_valid), 32'd1);
        step();
        step();
        req = 8'b0010_0101;
        step();
        check("gap_after_drop", 32'(grant), 32'd0);

        // Remaining requesters are served 5, 2, 0 and wrap back to 5.
        got        = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 100 && got < 4; c++) begin
            step();
            if (grant_valid && !prev_valid) begin
                seq[got] = grant_idx;
                got++;
            end
            prev_valid = grant_valid;
        end
        check("rr_count", 32'(got), 32'd4);
        check("rr_seq0", 32'(seq[0]), 32'd5);
        check("rr_seq1", 32'(seq[1]), 32'd2);
        check("rr_seq2", 32'(seq[2]), 32'd0);
        check("rr_seq3", 32'(seq[3]), 32'd5);

        // A lone persistent requester is revoked after MAX_HOLD cycles.
        req = 8'd0;
        for (int c = 0; c < 6; c++) step();
        req   = 8'b0000_1000;
        guard = 0;
        while (!grant_valid && guard < 5) begin
            step();
            guard++;
        end
        check("hold_start", 32'(grant_idx), 32'd3);
        held_cycles = 1;
        guard       = 0;
        step();
        while (grant_valid && guard < 20) begin
            held_cycles++;
            guard++;
            step();
        end
        check("hold_len", 32'(held_cycles), 32'(MAX_HOLD));
        check("hold_timeout", 32'(timeout), 32'd1);
        check("hold_cleared", 32'(grant), 32'd0);
        guard = 0;
        while (!grant_valid && guard < 5) begin
            step();
            guard++;
        end
        check("regrant_idx", 32'(grant_idx), 32'd3);
        check("regrant_no_timeout", 32'(timeout), 32'd0);

        // Other requests are ignored while the owner keeps requesting.
        req = 8'd0;
        for (int c = 0; c < 6; c++) step();
        req = 8'b0100_0000;
        step();
        check("own6_grant", 32'(grant), 32'h40);
        req = 8'b0100_0010;
        step();
        check("own6_hold_a", 32'(grant), 32'h40);
        step();
        check("own6_hold_b", 32'(grant), 32'h40);
        req = 8'b0000_0010;
        step();
        check("own6_release", 32'(grant), 32'd0);
        step();
        step();
        check("own1_grant", 32'(grant), 32'h02);

        // Asynchronous reset drops the grant before the next edge.
        req = 8'd0;
        for (int c = 0; c < 6; c++) step();
        req = 8'b0001_0000;
        step();
        check("pre_reset_grant", 32'(grant), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_valid", 32'(grant_valid), 32'd0);
        check("async_idx", 32'(grant_idx), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'b0000_0011;
        step();
        check("post_reset_idx", 32'(grant_idx), 32'd1);

        // Random traffic with some persistence in each request line.
        for (int c = 0; c < 10000; c++) begin
            req = req ^ (8'($urandom) & 8'($urandom));
            step();
            check("onehot", 32'($onehot0(grant)), 32'd1);
        end
        check("starve_bound", 32'(max_wait <= 7), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_arbiter_8.md
PRIORITY_ARBITER_8 -- requirements
Module: priority_arbiter_8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum consecutive cycles a single grant may be held (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  8  request lines, one per requester; bit i = requester i.
REQ-005 SHALL have port grant  output  8  one-hot grant vector, registered.
REQ-006 SHALL have port grant_idx  output  3  binary index of current grant, registered.
REQ-007 SHALL have port grant_valid  output  1  high when grant is non-zero.
REQ-008 SHALL have port timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, BUSY, GAP.
REQ-010 IDLE: when req != 0, SHALL select a winner and enter BUSY on the next edge, with grant/grant_idx/grant_valid registered in that same edge (1-cycle latency req -> grant).
REQ-011 IDLE with req == 0 SHALL remain in IDLE with grant = 0, grant_valid = 0.
REQ-012 Winner selection SHALL be round-robin, descending: with last-granted index L, search order is L-1, L-2, ..., 0, 7, 6, ..., L (mod 8); first asserted req bit in that order wins.
REQ-013 Selection SHALL use a rotate-and-mask scheme built on a highest-bit-wins 8-to-3 priority encoder, with wrap-around handled by a second, unmasked encoder pass when the masked set is empty.
REQ-014 Requester L (last granted) SHALL win only if no other req bit is asserted.
REQ-015 BUSY: grant SHALL be held stable while req[grant_idx] stays high and hold count < MAX_HOLD; changes on other req bits SHALL be ignored.
REQ-016 BUSY: hold counter (8 bits) SHALL clear on grant and increment each BUSY cycle; it SHALL not wrap.
REQ-017 BUSY -> GAP when req[grant_idx] drops; grant cleared on that edge, timeout = 0.
REQ-018 BUSY -> GAP when hold count reaches MAX_HOLD with req[grant_idx] still high; grant cleared and timeout pulsed high for exactly that one cycle.
REQ-019 If req[grant_idx] drops in the same cycle hold count reaches MAX_HOLD, release SHALL take precedence: timeout = 0.
REQ-020 GAP SHALL last exactly one cycle with grant = 0, then return to IDLE; minimum spacing between consecutive grants is therefore one empty cycle.
REQ-021 L SHALL update to grant_idx on every IDLE -> BUSY transition, and only then.
REQ-022 grant SHALL always be one-hot or zero; grant_idx SHALL be 0 whenever grant_valid = 0; grant_valid SHALL equal |grant.

Reset
REQ-023 rst_n low SHALL, asynchronously, force state = IDLE, grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0, hold count = 0, L = 0.
REQ-024 With L = 0 after reset, first search order SHALL be 7, 6, ..., 0 (plain highest-index priority).
REQ-025 Reset asserted mid-BUSY SHALL drop grant immediately without waiting for a clock edge; first grant after reset release follows REQ-024.

Verification
REQ-026 After reset, req = 8'b1010_0101 held -> next edge grant = 8'b1000_0000, grant_idx = 7, grant_valid = 1.
REQ-027 From REQ-026, drop req[7] after 3 cycles, keep others -> GAP cycle (grant = 0), then grant_idx = 5, then 2, then 0, then 5 again (round-robin wrap).
REQ-028 MAX_HOLD = 4, req[3] held permanently alone -> grant_idx = 3 for 4 cycles, timeout pulses once with grant = 0, GAP, then req[3] re-granted (sole requester).
REQ-029 req[6] granted, req[1] asserts during BUSY -> grant stays 8'b0100_0000 until req[6] falls; req[1] granted after GAP.
REQ-030 rst_n pulled low between clock edges during BUSY -> grant, grant_valid, grant_idx read 0 before the next edge; after release, req = 8'b0000_0011 -> grant_idx = 1.
REQ-031 Random req traffic for 10k cycles -> scoreboard checks one-hot grant, no requester starved beyond 7 grants of others, timeout only at MAX_HOLD.
